// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : timer_pkg
// Description : Shared types and constants for the interval timer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Default counter / period width
  localparam int unsigned TIMER_N_DEFAULT = 4;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/interval_timer_ctrl_sync_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_counter
// Description : N-bit synchronous up-counter with clear and enable. Clear
//               wins over enable; everything runs on the single system clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_counter #(
  parameter int N = 4
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [N-1:0] count_o
);

  logic [N-1:0] count_q;

  // Count register: reset and clear return to zero, enable steps by one
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule : sync_counter
`default_nettype wire

// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_ctrl
// Description : Programmable interval timer controller. Sequences an N-bit
//               counter in one-shot or periodic mode with pause, abort and a
//               done/acknowledge handshake. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int N = TIMER_N_DEFAULT
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [N-1:0] period_i,
  input  logic         mode_i,
  input  logic         pause_i,
  input  logic         abort_i,
  input  logic         done_ack_i,
  output logic [N-1:0] count_o,
  output logic         busy_o,
  output logic         tick_o,
  output logic         done_o,
  output logic         err_o
);

  state_e       state_q, state_d;
  logic [N-1:0] period_q, period_d;
  logic         mode_q, mode_d;
  logic         busy_q, busy_d;
  logic         tick_q, tick_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         cnt_clr, cnt_en;
  logic [N-1:0] count;

  sync_counter #(
    .N (N)
  ) u_counter (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (count)
  );

  // Next-state, counter control and registered-output targets.
  // Priority: abort, then pause (freezes everything), then start/ack/counting.
  // A deasserted pause while PAUSED acts immediately as a RUN cycle, so a
  // pause lasting M cycles delays the terminal event by exactly M cycles.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    done_d   = done_q;
    err_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      cnt_clr = 1'b1;
    end else if (pause_i) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSED;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (period_i != '0) begin
              period_d = period_i;
              mode_d   = mode_i;
              state_d  = ST_RUN;
              cnt_clr  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN, ST_PAUSED: begin
          state_d = ST_RUN;
          if (count != period_q) begin
            cnt_en = 1'b1;
          end else begin
            tick_d = 1'b1;
            if (mode_q) begin
              cnt_clr = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (done_ack_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            cnt_clr = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, latched configuration and registered outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign count_o = count;
  assign busy_o  = busy_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule : interval_timer_ctrl
`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_timer_ctrl
// Description : Self-checking bench for interval_timer_ctrl: directed
//               scenarios followed by random stimulus, all compared every
//               cycle against a behavioural timer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_timer_ctrl;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] period = '0;
  logic         mode = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic         done_ack = 1'b0;
  logic [N-1:0] count;
  logic         busy, tick, done, err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: an active timer counting up to its latched period
  int m_cnt = 0, m_p = 0;
  bit m_busy = 0, m_done = 0, m_tick = 0, m_err = 0, m_per = 0;

  interval_timer_ctrl #(.N(N)) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .start_i    (start),
    .period_i   (period),
    .mode_i     (mode),
    .pause_i    (pause),
    .abort_i    (abort),
    .done_ack_i (done_ack),
    .count_o    (count),
    .busy_o     (busy),
    .tick_o     (tick),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_step();
    m_tick = 0;
    m_err  = 0;
    if (reset) begin
      m_busy = 0; m_done = 0; m_cnt = 0; m_p = 0; m_per = 0;
    end else if (abort) begin
      m_busy = 0; m_done = 0; m_cnt = 0;
    end else if (pause) begin
      // everything frozen
    end else if (!m_busy) begin
      if (start) begin
        if (period != 0) begin
          m_busy = 1; m_p = int'(period); m_per = mode; m_cnt = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_done) begin
      if (done_ack) begin
        m_busy = 0; m_done = 0; m_cnt = 0;
      end
    end else if (m_cnt < m_p) begin
      m_cnt++;
    end else begin
      m_tick = 1;
      if (m_per) m_cnt = 0;
      else       m_done = 1;
    end
  endtask

  // One clock edge: update model, then compare all outputs shortly after
  task automatic step();
    @(posedge clock);
    model_step();
    cyc++;
    #1;
    check("count", 32'(count), 32'(m_cnt));
    check("busy",  32'(busy),  32'(m_busy));
    check("tick",  32'(tick),  32'(m_tick));
    check("done",  32'(done),  32'(m_done));
    check("err",   32'(err),   32'(m_err));
  endtask

  task automatic do_start(input logic [N-1:0] p, input logic md);
    start = 1'b1; period = p; mode = md;
    step();
    start = 1'b0;
  endtask

  initial begin
    int t1, t2, nticks;

    // Reset held for two cycles, then idle with no activity
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("idle_count", 32'(count), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // One-shot, P=5
    do_start(4'd5, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("os_count5", 32'(count), 32'd5);
    check("os_notick_yet", 32'(tick), 32'd0);
    step();
    check("os_tick", 32'(tick), 32'd1);
    check("os_done", 32'(done), 32'd1);
    check("os_count_hold", 32'(count), 32'd5);
    step();
    check("os_tick_fall", 32'(tick), 32'd0);
    check("os_done_hold", 32'(done), 32'd1);
    done_ack = 1'b1; step(); done_ack = 1'b0;
    check("os_ack_done", 32'(done), 32'd0);
    check("os_ack_busy", 32'(busy), 32'd0);
    check("os_ack_count", 32'(count), 32'd0);

    // Periodic, P=3: ticks every 4 cycles, then abort
    do_start(4'd3, 1'b1);
    t1 = -1; nticks = 0;
    for (int i = 0; i < 40 && nticks < 3; i++) begin
      step();
      if (tick) begin
        if (t1 >= 0) check("per_interval", 32'(cyc - t1), 32'd4);
        t1 = cyc; nticks++;
      end
    end
    check("per_tick_count", 32'(nticks), 32'd3);
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_count", 32'(count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    nticks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick) nticks++;
    end
    check("abort_no_tick", 32'(nticks), 32'd0);

    // Periodic, P=15, pause 3 cycles while count==15
    do_start(4'd15, 1'b1);
    for (int i = 0; i < 40 && !m_tick; i++) step();
    check("p15_first_tick", 32'(tick), 32'd1);
    t1 = cyc;
    for (int i = 0; i < 40 && m_cnt != 15; i++) step();
    check("p15_at_15", 32'(count), 32'd15);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("p15_hold", 32'(count), 32'd15);
    pause = 1'b0;
    for (int i = 0; i < 40 && !m_tick; i++) step();
    t2 = cyc;
    check("p15_interval", 32'(t2 - t1), 32'd19);
    check("p15_wrap", 32'(count), 32'd0);
    abort = 1'b1; step(); abort = 1'b0;

    // Rejected start and start while busy
    do_start(4'd0, 1'b0);
    check("err_pulse", 32'(err), 32'd1);
    step();
    check("err_fall", 32'(err), 32'd0);
    check("err_idle", 32'(busy), 32'd0);
    do_start(4'd6, 1'b0);
    step(); step();
    start = 1'b1; period = 4'd9; mode = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && !m_done; i++) step();
    check("busy_start_done", 32'(done), 32'd1);
    check("busy_start_period", 32'(count), 32'd6);

    // Reset in DONE
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_done_busy", 32'(busy), 32'd0);
    check("rst_done_done", 32'(done), 32'd0);

    // Reset in PAUSED
    do_start(4'd4, 1'b1);
    step(); step();
    pause = 1'b1; step(); step();
    reset = 1'b1; step(); reset = 1'b0; pause = 1'b0;
    check("rst_paused_count", 32'(count), 32'd0);
    check("rst_paused_tick", 32'(tick), 32'd0);

    // Start P=2 after reset: tick after edge 3
    do_start(4'd2, 1'b0);
    step(); step();
    check("p2_no_tick", 32'(tick), 32'd0);
    step();
    check("p2_tick", 32'(tick), 32'd1);
    done_ack = 1'b1; step(); done_ack = 1'b0;

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(63) == 0);
      abort    = ($urandom_range(31) == 0);
      pause    = ($urandom_range(4) == 0);
      start    = ($urandom_range(3) == 0);
      done_ack = ($urandom_range(3) == 0);
      period   = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15));
      mode     = 1'($urandom_range(1));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_interval_timer_ctrl
`default_nettype wire
